// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetcher feeding a two-entry
// FIFO that presents its head entry to the IF/ID register. Branch redirects flush
// the FIFO and, if a request is in flight, drop its response.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  localparam logic [1:0] Full = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic        push, pop;
  logic [1:0]  slot;

  // Low target bits are word-alignment only and are discarded.
  logic unused_tgt;
  assign unused_tgt = ^BranchTarget[1:0];

  // Next-state logic: redirect has priority, otherwise FSM plus FIFO push/pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    instr0_d   = instr0_q;
    instr1_d   = instr1_q;
    push       = 1'b0;
    pop        = 1'b0;
    slot       = 2'd0;

    if (BranchTaken) begin
      count_d    = 2'd0;
      fetch_pc_d = {BranchTarget[63:2], 2'b00};
      state_d    = (state_q == StIdle) ? StIdle : StDiscard;
    end else begin
      pop = (count_q != 2'd0) && !Stall;

      unique case (state_q)
        StIdle: begin
          if (count_q < Full) state_d = StWait;
        end
        StWait: begin
          if (imem_ready) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 64'd4;
          end
        end
        StDiscard: begin
          if (imem_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      // Shift the FIFO on pop; then the push lands in the first free slot.
      if (pop) begin
        pc0_d    = pc1_q;
        instr0_d = instr1_q;
      end
      slot = count_q - {1'b0, pop};
      if (push) begin
        if (slot == 2'd0) begin
          pc0_d    = fetch_pc_q;
          instr0_d = imem_rdata;
        end else begin
          pc1_d    = fetch_pc_q;
          instr1_d = imem_rdata;
        end
      end
      count_d = slot + {1'b0, push};

      // Only reissue while a slot will still be free when the next response lands.
      if (push) state_d = (count_d <= 2'd1) ? StWait : StIdle;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      pc0_q      <= RESET_PC;
      pc1_q      <= 64'h0;
      instr0_q   <= 32'h0;
      instr1_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
    end
  end

  // Output decode.
  always_comb begin
    imem_req  = (state_q != StIdle);
    imem_addr = fetch_pc_q;
    if_valid  = (count_q != 2'd0);
    if_pc     = pc0_q;
    if_instr  = if_valid ? instr0_q : 32'h0;
  end

endmodule
